// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: button presses -> operand entry, op select, ALU evaluation, hex digits.
// Optional restoring divider (op 11) is built when CALC_DIV_EN is defined.
module calc_entry_ctrl #(
  parameter int OPERAND_W = 4,
  parameter int BLINK_DIV = 12_500_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Btn_Inc,
  input  logic       i_Btn_Op,
  input  logic       i_Btn_Next,
  input  logic       i_Btn_Clr,
  output logic [3:0] o_Digit_Hi,
  output logic [3:0] o_Digit_Lo,
  output logic       o_Blank,
  output logic [1:0] o_Op,
  output logic       o_Busy,
  output logic       o_Err
);
  localparam int RW    = 2 * OPERAND_W;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [2:0] {S_A, S_B, S_CALC, S_RES, S_ERR} state_t;

  state_t               state_q, state_d;
  logic [OPERAND_W-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]           op_q, op_d;
  logic [3:0]           hi_q, hi_d, lo_q, lo_d;
  logic                 blank_q, blank_d, busy_q, busy_d, err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           prev_q, prev_d;
  logic [3:0]           lvl, press;
  logic                 p_clr, p_next, p_op, p_inc, acted;
  logic [RW-1:0]        res;
  logic [7:0]           res8;
`ifdef CALC_DIV_EN
  localparam int DCNT_W = (OPERAND_W > 1) ? $clog2(OPERAND_W) : 1;
  logic [OPERAND_W-1:0] quo_q, quo_d, rem_q, rem_d;
  logic [DCNT_W-1:0]    dcnt_q, dcnt_d;
  logic [OPERAND_W:0]   shifted;
  logic                 ge;
`endif

  function automatic logic [1:0] next_op(input logic [1:0] op);
`ifdef CALC_DIV_EN
    return op + 2'd1;
`else
    return (op == 2'b10) ? 2'b00 : op + 2'd1;
`endif
  endfunction

  // Button order {clr, next, op, inc}; only the highest-priority press is kept.
  always_comb begin
    lvl    = {i_Btn_Clr, i_Btn_Next, i_Btn_Op, i_Btn_Inc};
    prev_d = lvl;
    press  = lvl & ~prev_q;
    p_clr  = press[3];
    p_next = press[2] & ~press[3];
    p_op   = press[1] & ~|press[3:2];
    p_inc  = press[0] & ~|press[3:1];
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acted   = 1'b0;
    res     = '0;
    res8    = '0;
`ifdef CALC_DIV_EN
    quo_d   = quo_q;
    rem_d   = rem_q;
    dcnt_d  = dcnt_q;
    shifted = '0;
    ge      = 1'b0;
`endif
    if (p_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = 2'b00;
      acted   = 1'b1;
    end else begin
      case (state_q)
        S_A, S_B: begin
          if (p_next) begin
            state_d = (state_q == S_A) ? S_B : S_CALC;
            acted   = 1'b1;
`ifdef CALC_DIV_EN
            quo_d  = a_q;
            rem_d  = '0;
            dcnt_d = '0;
`endif
          end else if (p_op) begin
            op_d  = next_op(op_q);
            acted = 1'b1;
          end else if (p_inc) begin
            if (state_q == S_A) a_d = a_q + OPERAND_W'(1);
            else                b_d = b_q + OPERAND_W'(1);
            acted = 1'b1;
          end
        end
        S_CALC: begin
`ifdef CALC_DIV_EN
          if (op_q == 2'b11) begin
            if (b_q == '0) begin
              state_d = S_ERR;
            end else begin
              // Restoring step: shift in next dividend bit, subtract divisor if it fits.
              shifted = {rem_q, quo_q[OPERAND_W-1]};
              ge      = shifted >= {1'b0, b_q};
              quo_d   = {quo_q[OPERAND_W-2:0], ge};
              rem_d   = ge ? OPERAND_W'(shifted - {1'b0, b_q}) : shifted[OPERAND_W-1:0];
              dcnt_d  = dcnt_q + DCNT_W'(1);
              if (dcnt_q == DCNT_W'(OPERAND_W - 1)) begin
                state_d = S_RES;
                hi_d    = 4'(quo_d);
                lo_d    = 4'(rem_d);
              end
            end
          end else
`endif
          begin
            state_d = S_RES;
            case (op_q)
              2'b01: begin
                if (a_q < b_q) state_d = S_ERR;
                res = RW'(a_q) - RW'(b_q);
              end
              2'b10:   res = RW'(a_q) * RW'(b_q);
              default: res = RW'(a_q) + RW'(b_q);
            endcase
            res8 = 8'(res);
            hi_d = res8[7:4];
            lo_d = res8[3:0];
          end
        end
        S_RES, S_ERR: begin
          if (p_next) begin
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            acted   = 1'b1;
          end
        end
        default: state_d = S_A;
      endcase
    end

    case (state_d)
      S_A:     begin hi_d = 4'h0; lo_d = 4'(a_d); end
      S_B:     begin hi_d = 4'h0; lo_d = 4'(b_d); end
      S_ERR:   begin hi_d = 4'hE; lo_d = 4'hE; end
      default: ;
    endcase
    busy_d = (state_d == S_CALC);
    err_d  = (state_d == S_ERR);

    // Blink restarts visible on every acted press or state change, and only runs while editing.
    if (acted || (state_d != state_q) || !((state_d == S_A) || (state_d == S_B))) begin
      cnt_d   = '0;
      blank_d = 1'b0;
    end else if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      blank_d = ~blank_q;
    end else begin
      cnt_d   = cnt_q + CNT_W'(1);
      blank_d = blank_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 2'b00;
      hi_q    <= 4'h0;
      lo_q    <= 4'h0;
      blank_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 4'b1111;
`ifdef CALC_DIV_EN
      quo_q   <= '0;
      rem_q   <= '0;
      dcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
`ifdef CALC_DIV_EN
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dcnt_q  <= dcnt_d;
`endif
    end
  end

  assign o_Digit_Hi = hi_q;
  assign o_Digit_Lo = lo_q;
  assign o_Blank    = blank_q;
  assign o_Op       = op_q;
  assign o_Busy     = busy_q;
  assign o_Err      = err_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Directed bench for calc_entry_ctrl (BLINK_DIV=4); divider scenario compiled in with CALC_DIV_EN.
module tb_calc_entry_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b_inc = 1'b0, b_op = 1'b0, b_next = 1'b0, b_clr = 1'b0;
  logic [3:0] o_Digit_Hi, o_Digit_Lo;
  logic       o_Blank, o_Busy, o_Err;
  logic [1:0] o_Op;
  int         checks = 0;
  int         errors = 0;

  localparam int INC = 0, OP = 1, NEXT = 2, CLR = 3;

  calc_entry_ctrl #(.OPERAND_W(4), .BLINK_DIV(4)) dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_Btn_Inc(b_inc), .i_Btn_Op(b_op), .i_Btn_Next(b_next), .i_Btn_Clr(b_clr),
    .o_Digit_Hi(o_Digit_Hi), .o_Digit_Lo(o_Digit_Lo), .o_Blank(o_Blank),
    .o_Op(o_Op), .o_Busy(o_Busy), .o_Err(o_Err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      INC:     b_inc  = v;
      OP:      b_op   = v;
      NEXT:    b_next = v;
      default: b_clr  = v;
    endcase
  endtask

  // Returns on the falling edge right after the press was acted on.
  task automatic press(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); set_btn(b, 1'b1);
      @(negedge clk); set_btn(b, 1'b0);
    end
  endtask

  task automatic test_reset;
    b_inc = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({o_Digit_Hi, o_Digit_Lo} !== 8'h00) begin errors++; $display("FAIL rst_digits: got %h expected 00", {o_Digit_Hi, o_Digit_Lo}); end
    checks++; if ({o_Blank, o_Op, o_Busy, o_Err} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b expected 00000", {o_Blank, o_Op, o_Busy, o_Err}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_Digit_Lo !== 4'h0) begin errors++; $display("FAIL held_inc_reset: got %h expected 0", o_Digit_Lo); end
    b_inc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    press(INC, 3);
    checks++; if (o_Digit_Lo !== 4'h3) begin errors++; $display("FAIL add_a: got %h expected 3", o_Digit_Lo); end
    press(NEXT, 1);
    press(INC, 5);
    checks++; if (o_Digit_Lo !== 4'h5) begin errors++; $display("FAIL add_b: got %h expected 5", o_Digit_Lo); end
    press(NEXT, 1);
    checks++; if ({o_Busy, o_Digit_Lo} !== 5'h15) begin errors++; $display("FAIL add_busy: got %h expected 15", {o_Busy, o_Digit_Lo}); end
    @(negedge clk);
    checks++; if ({o_Busy, o_Err, o_Digit_Hi, o_Digit_Lo} !== 10'h008) begin errors++; $display("FAIL add_res: got %h expected 008", {o_Busy, o_Err, o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1);
  endtask

  task automatic test_sub_err;
    press(OP, 1);
    checks++; if (o_Op !== 2'b01) begin errors++; $display("FAIL sub_op: got %b expected 01", o_Op); end
    press(INC, 2); press(NEXT, 1); press(INC, 7); press(NEXT, 1);
    @(negedge clk);
    checks++; if ({o_Err, o_Busy, o_Digit_Hi, o_Digit_Lo} !== 10'h2EE) begin errors++; $display("FAIL sub_err: got %h expected 2ee", {o_Err, o_Busy, o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1);
    checks++; if ({o_Err, o_Digit_Lo, o_Op} !== 7'b0_0000_01) begin errors++; $display("FAIL sub_exit: got %b expected 0000001", {o_Err, o_Digit_Lo, o_Op}); end
  endtask

  task automatic test_mul;
    press(OP, 1);
    checks++; if (o_Op !== 2'b10) begin errors++; $display("FAIL mul_op: got %b expected 10", o_Op); end
    press(INC, 15); press(NEXT, 1); press(INC, 15); press(NEXT, 1);
    @(negedge clk);
    checks++; if ({o_Digit_Hi, o_Digit_Lo} !== 8'hE1) begin errors++; $display("FAIL mul_res: got %h expected e1", {o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1);
    press(INC, 17);
    checks++; if (o_Digit_Lo !== 4'h1) begin errors++; $display("FAIL inc_wrap: got %h expected 1", o_Digit_Lo); end
    press(OP, 1);
`ifdef CALC_DIV_EN
    checks++; if (o_Op !== 2'b11) begin errors++; $display("FAIL op_div: got %b expected 11", o_Op); end
    press(OP, 1);
`endif
    checks++; if (o_Op !== 2'b00) begin errors++; $display("FAIL op_wrap: got %b expected 00", o_Op); end
  endtask

  task automatic test_priority;
    @(negedge clk); b_inc = 1'b1; b_next = 1'b1;
    @(negedge clk); b_inc = 1'b0; b_next = 1'b0;
    checks++; if ({o_Busy, o_Digit_Lo} !== 5'h00) begin errors++; $display("FAIL prio_sb: got %h expected 00", {o_Busy, o_Digit_Lo}); end
    press(NEXT, 1);
    @(negedge clk);
    checks++; if ({o_Digit_Hi, o_Digit_Lo} !== 8'h01) begin errors++; $display("FAIL prio_a_kept: got %h expected 01", {o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1);
    press(INC, 2); press(OP, 1);
    @(negedge clk); b_clr = 1'b1; b_inc = 1'b1; b_op = 1'b1;
    @(negedge clk); b_clr = 1'b0; b_inc = 1'b0; b_op = 1'b0;
    checks++; if ({o_Digit_Lo, o_Op} !== 6'b0000_00) begin errors++; $display("FAIL prio_clr: got %b expected 000000", {o_Digit_Lo, o_Op}); end
  endtask

  task automatic test_blink;
    press(CLR, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++; if (o_Blank !== (k >= 4)) begin errors++; $display("FAIL blink_idle_%0d: got %b expected %b", k, o_Blank, (k >= 4)); end
    end
    b_inc = 1'b1;
    @(negedge clk); b_inc = 1'b0;
    checks++; if ({o_Blank, o_Digit_Lo} !== 5'h01) begin errors++; $display("FAIL blink_inc: got %h expected 01", {o_Blank, o_Digit_Lo}); end
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checks++; if (o_Blank !== (j >= 4 && j < 8)) begin errors++; $display("FAIL blink_restart_%0d: got %b expected %b", j, o_Blank, (j >= 4 && j < 8)); end
    end
    press(NEXT, 2);
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      checks++; if (o_Blank !== 1'b0) begin errors++; $display("FAIL blink_res_%0d: got %b expected 0", j, o_Blank); end
    end
    press(NEXT, 1);
  endtask

`ifdef CALC_DIV_EN
  task automatic test_div;
    int n;
    press(CLR, 1); press(OP, 3);
    checks++; if (o_Op !== 2'b11) begin errors++; $display("FAIL div_op: got %b expected 11", o_Op); end
    press(INC, 13); press(NEXT, 1); press(INC, 4); press(NEXT, 1);
    n = 0;
    while (o_Busy === 1'b1 && n < 20) begin n++; @(negedge clk); end
    checks++; if (n !== 4) begin errors++; $display("FAIL div_busy_cycles: got %0d expected 4", n); end
    checks++; if ({o_Err, o_Digit_Hi, o_Digit_Lo} !== 9'h031) begin errors++; $display("FAIL div_res: got %h expected 031", {o_Err, o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1); press(INC, 3); press(NEXT, 2);
    @(negedge clk);
    checks++; if ({o_Err, o_Busy, o_Digit_Hi, o_Digit_Lo} !== 10'h2EE) begin errors++; $display("FAIL div_zero: got %h expected 2ee", {o_Err, o_Busy, o_Digit_Hi, o_Digit_Lo}); end
    press(NEXT, 1); press(INC, 5); press(NEXT, 1); press(INC, 2); press(NEXT, 1);
    b_clr = 1'b1;
    @(negedge clk); b_clr = 1'b0;
    checks++; if ({o_Busy, o_Err, o_Op, o_Digit_Hi, o_Digit_Lo} !== 12'h000) begin errors++; $display("FAIL div_abort: got %h expected 000", {o_Busy, o_Err, o_Op, o_Digit_Hi, o_Digit_Lo}); end
    repeat (2) @(negedge clk);
    checks++; if ({o_Busy, o_Digit_Lo} !== 5'h00) begin errors++; $display("FAIL div_abort_hold: got %h expected 00", {o_Busy, o_Digit_Lo}); end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub_err;
    test_mul;
    test_priority;
    test_blink;
`ifdef CALC_DIV_EN
    test_div;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
